// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC/IR registers, next-PC select and an imem request/valid handshake with timeout.
// Optional macro BRANCH_CNT_EN adds a saturating counter of taken non-sequential PC writes.
module pc_fetch_unit #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              Write_PC,
  input  logic              Write_IR,
  input  logic [1:0]        PC_s,
  input  logic [31:0]       F,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic              imem_req,
  output logic [ADDR_W-1:0] Inst_addr,
  output logic [31:0]       PC,
  output logic [31:0]       I,
  output logic              busy,
  output logic              fetch_err,
  output logic [15:0]       branch_cnt
);

  localparam logic [0:0]  S_IDLE = 1'b0;
  localparam logic [0:0]  S_WAIT = 1'b1;
  localparam int          CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [31:0] NOP    = 32'hE1A0_0000;

  logic [0:0]        state;
  logic [CNT_W-1:0]  tcnt;
  logic [ADDR_W-1:0] faddr;
  logic [31:0]       next_pc;
  logic [31:0]       br_off;
  logic              last_wait;

  assign br_off    = {{6{I[23]}}, I[23:0], 2'b00};
  assign busy      = (state == S_WAIT);
  assign Inst_addr = busy ? faddr : PC[ADDR_W+1:2];
  // Final permitted WAIT cycle: counter would reach TIMEOUT this edge.
  assign last_wait = (tcnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    next_pc = PC;
    case (PC_s)
      2'b00:   next_pc = PC + 32'd4;
      2'b01:   next_pc = PC + 32'd4 + br_off;
      2'b10:   next_pc = F & 32'hFFFF_FFFC;
      default: next_pc = PC;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst)           PC <= RESET_PC;
    else if (Write_PC) PC <= next_pc;
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state     <= S_IDLE;
      I         <= 32'h0;
      imem_req  <= 1'b0;
      fetch_err <= 1'b0;
      tcnt      <= '0;
      faddr     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Write_IR) begin
            faddr    <= PC[ADDR_W+1:2];
            tcnt     <= '0;
            imem_req <= 1'b1;
            state    <= S_WAIT;
          end
        end
        default: begin
          // Valid takes priority over the timeout on the same cycle.
          if (imem_valid) begin
            I        <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_IDLE;
          end else if (last_wait) begin
            I         <= NOP;
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            state     <= S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef BRANCH_CNT_EN
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst)
      branch_cnt <= 16'h0;
    else if (Write_PC && (PC_s == 2'b01 || PC_s == 2'b10) && branch_cnt != 16'hFFFF)
      branch_cnt <= branch_cnt + 16'h1;
  end
`else
  assign branch_cnt = 16'h0;
`endif

endmodule
